// File: rtl/gate_pkg.sv
// Shared encodings and the reference truth function for the 2-input gate benches.
package gate_pkg;

   localparam logic [1:0] FUNC_AND  = 2'd0;
   localparam logic [1:0] FUNC_OR   = 2'd1;
   localparam logic [1:0] FUNC_XOR  = 2'd2;
   localparam logic [1:0] FUNC_NAND = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic gate_expect(input logic [1:0] func, input logic a, input logic b);
      logic r;
      case (func)
         FUNC_AND:  r = a & b;
         FUNC_OR:   r = a | b;
         FUNC_XOR:  r = a ^ b;
         default:   r = ~(a & b);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sweep_hold_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag.
module sweep_hold_counter #(
   parameter int W    = 8,
   parameter int TERM = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   localparam logic [W-1:0] TERM_V = W'(TERM);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign tc = (count == TERM_V);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a 2-input gate through 00,01,10,11, samples y once per vector and scores it.
// Optional GATE_SWEEP_LOG_EN adds y_log, the per-vector sampled y values.
module gate_sweep_checker
   import gate_pkg::*;
#(
   parameter int HOLD_CYCLES = 10,
   parameter int SAMPLE_AT   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] func,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count
`ifdef GATE_SWEEP_LOG_EN
  ,output logic [3:0] y_log
`endif
);

   localparam logic [7:0] SAMPLE_V = 8'(SAMPLE_AT);

   state_t     state, state_n;
   logic [1:0] vec, vec_n;
   logic [1:0] func_q, func_n;
   logic [2:0] err_n;
   logic       cnt_clr, cnt_en, cnt_tc;
   logic [7:0] cnt;
   logic       mismatch;

   sweep_hold_counter #(.W(8), .TERM(HOLD_CYCLES - 1)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cnt),
      .tc    (cnt_tc)
   );

   // Case inequality so an X/Z on y scores as a mismatch in simulation.
   assign mismatch = (y !== gate_expect(func_q, vec[1], vec[0]));

`ifdef GATE_SWEEP_LOG_EN
   logic [3:0] log_n;
`endif

   always_comb begin
      state_n = state;
      vec_n   = vec;
      func_n  = func_q;
      err_n   = err_count;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
`ifdef GATE_SWEEP_LOG_EN
      log_n   = y_log;
`endif
      case (state)
         ST_DRIVE: begin
            cnt_en = 1'b1;
            if (cnt == SAMPLE_V) begin
               if (mismatch && err_count != 3'd4)
                  err_n = err_count + 3'd1;
`ifdef GATE_SWEEP_LOG_EN
               log_n[vec] = y;
`endif
            end
            if (cnt_tc) begin
               cnt_clr = 1'b1;
               if (vec == 2'd3)
                  state_n = ST_DONE;
               else
                  vec_n = vec + 2'd1;
            end
         end
         default: begin
            // IDLE and DONE both accept a new sweep.
            if (start) begin
               state_n = ST_DRIVE;
               func_n  = func;
               vec_n   = 2'd0;
               err_n   = 3'd0;
               cnt_clr = 1'b1;
`ifdef GATE_SWEEP_LOG_EN
               log_n   = 4'd0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         vec       <= 2'd0;
         func_q    <= FUNC_OR;
         err_count <= 3'd0;
`ifdef GATE_SWEEP_LOG_EN
         y_log     <= 4'd0;
`endif
      end else begin
         state     <= state_n;
         vec       <= vec_n;
         func_q    <= func_n;
         err_count <= err_n;
`ifdef GATE_SWEEP_LOG_EN
         y_log     <= log_n;
`endif
      end
   end

   assign a    = vec[1];
   assign b    = vec[0];
   assign busy = (state == ST_DRIVE);
   assign done = (state == ST_DONE);
   assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized scoreboard bench for gate_sweep_checker; a reference model predicts each sweep.
module tb_gate_sweep_checker;

   localparam int H  = 10;
   localparam int H2 = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, start2 = 1'b0;
   logic [1:0] func = 2'd0, func2 = 2'd0;
   logic       y, y2;
   logic       a, b, busy, done, pass;
   logic       a2, b2, busy2, done2, pass2;
   logic [2:0] err_count, err_count2;
`ifdef GATE_SWEEP_LOG_EN
   logic [3:0] y_log, y_log2;
`endif
   int         y_mode = 1, y2_mode = 2;
   int         cyc = 0;
   int         checks = 0, errors = 0;

   typedef struct {
      int         acc;
      int         err;
      logic [3:0] log;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Truth tables as arithmetic; codes 0..3 = AND/OR/XOR/NAND, anything else = stuck-at-0.
   function automatic int ref_fn(input int f, input int x, input int z);
      case (f)
         0: return x * z;
         1: return (x + z > 0) ? 1 : 0;
         2: return (x + z == 1) ? 1 : 0;
         3: return 1 - x * z;
         default: return 0;
      endcase
   endfunction

   always_comb y  = (ref_fn(y_mode,  int'(a),  int'(b))  != 0);
   always_comb y2 = (ref_fn(y2_mode, int'(a2), int'(b2)) != 0);

   gate_sweep_checker #(.HOLD_CYCLES(H), .SAMPLE_AT(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .y(y),
      .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_SWEEP_LOG_EN
     ,.y_log(y_log)
`endif
   );

   gate_sweep_checker #(.HOLD_CYCLES(H2), .SAMPLE_AT(1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .func(func2), .y(y2),
      .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2)
`ifdef GATE_SWEEP_LOG_EN
     ,.y_log(y_log2)
`endif
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t predict(input int f, input int m, input int acc);
      exp_t e;
      e.acc = acc;
      e.err = 0;
      e.log = 4'd0;
      for (int v = 0; v < 4; v++) begin
         if (ref_fn(f, v / 2, v % 2) != ref_fn(m, v / 2, v % 2)) e.err++;
         e.log[v] = (ref_fn(m, v / 2, v % 2) != 0);
      end
      return e;
   endfunction

   // Monitor: a/b follow the model's vector while busy; on each rising done pop and compare.
   initial begin
      logic done_q;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (busy) begin
            if (sb.size() == 0) chk("busy_without_expect", 1, 0);
            else begin
               int v;
               v = (cyc - sb[0].acc) / H;
               chk("vec_ab", int'({a, b}), v);
            end
         end
         if (done && !done_q) begin
            if (sb.size() == 0) chk("done_without_expect", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("latency", cyc - e.acc, 4 * H);
               chk("err_count", int'(err_count), e.err);
               chk("pass", int'(pass), (e.err == 0) ? 1 : 0);
               chk("final_ab", int'({a, b}), 3);
`ifdef GATE_SWEEP_LOG_EN
               chk("y_log", int'(y_log), int'(e.log));
`endif
            end
         end
         done_q = done;
      end
   end

   // One sweep on the main DUT; poke>0 pulses an (ignored) start that many cycles in.
   task automatic run_sweep(input int f, input int m, input int poke);
      int n;
      @(negedge clk);
      func   = 2'(f);
      y_mode = m;
      start  = 1'b1;
      sb.push_back(predict(f, m, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      chk("accept_busy", int'(busy), 1);
      chk("accept_done", int'(done), 0);
      n = 1;
      while (!done && n < 4 * H + 8) begin
         if (n == poke) begin
            start = 1'b1;
            func  = ~2'(f);
         end else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!done) begin
         chk("sweep_timeout", 0, 1);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_sweep2(input int f, input int m);
      int acc, n;
      exp_t e;
      @(negedge clk);
      func2   = 2'(f);
      y2_mode = m;
      start2  = 1'b1;
      acc     = cyc + 1;
      e       = predict(f, m, acc);
      @(negedge clk);
      start2 = 1'b0;
      chk("h2_accept_done", int'(done2), 0);
      n = 0;
      while (!done2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("h2_latency", cyc - acc, 4 * H2);
      chk("h2_err_count", int'(err_count2), e.err);
      chk("h2_pass", int'(pass2), (e.err == 0) ? 1 : 0);
`ifdef GATE_SWEEP_LOG_EN
      chk("h2_y_log", int'(y_log2), int'(e.log));
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_a", int'(a), 0);
      chk("rst_b", int'(b), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_count), 0);

      run_sweep(1, 1, 0);    // OR vs or_gate: clean
      run_sweep(1, 4, 0);    // OR vs stuck-at-0: three misses
      run_sweep(0, 1, 0);    // AND vs or_gate: two misses
      run_sweep(1, 1, 15);   // start pulse mid-sweep is ignored

      // Reset in the middle of a sweep.
      @(negedge clk);
      func = 2'd1; y_mode = 1; start = 1'b1;
      sb.push_back(predict(1, 1, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      repeat (24) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      chk("midrst_ab", int'({a, b}), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_err", int'(err_count), 0);

      run_sweep(1, 1, 0);    // clean sweep after reset
      run_sweep(2, 2, 0);    // restart straight from DONE with XOR
      for (int i = 0; i < 8; i++)
         run_sweep(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0);

      run_sweep2(2, 2);
      run_sweep2(2, 2);      // restart from DONE on the short-hold instance
      for (int i = 0; i < 4; i++)
         run_sweep2(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synchronous stimulus/checker stage placed directly upstream of a 2-input gate (or_gate and its siblings).
- Drives the gate's a/b inputs through the full truth table 00, 01, 10, 11, holding each vector for a fixed number of cycles.
- Samples the gate's y output once per vector, compares it against the expected function and reports a pass/fail summary.
- Replaces hand-written delay/display sequences in the gate benches with a reusable, synthesizable sequencer.

Parameters:
- HOLD_CYCLES, 10, cycles each vector is held on a/b; legal range 2..255.
- SAMPLE_AT, 1, 0-based cycle within the hold window at which y is sampled; must be < HOLD_CYCLES.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- func  input  2  expected gate: 0=AND, 1=OR, 2=XOR, 3=NAND; latched on accepted start.
- y  input  1  output of the gate under test.
- a  output  1  gate input a; equals vec[1].
- b  output  1  gate input b; equals vec[0].
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE until the next accepted start or rst.
- pass  output  1  done && (err_count == 0).
- err_count  output  3  number of mismatching vectors in the last sweep, 0..4.

Behaviour:
- Reset (rst=1 at an edge, any state including mid-sweep) sets:
  - state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0.
  - Internal vec=0, hold counter=0, func_q=1 (OR).
  - Reset has priority over start.
- State IDLE:
  - start=1 moves to DRIVE.
  - Latches func_q=func, sets vec=0 (a=0, b=0), clears hold counter and err_count, sets busy=1.
- State DRIVE:
  - Hold counter increments by 1 every cycle; the cycle of entry is count 0.
  - At count==SAMPLE_AT, compare y with expected(func_q, vec). On mismatch, err_count+=1 (saturating at 4, cannot exceed 4 by construction).
  - At count==HOLD_CYCLES-1 with vec<3: vec+=1, counter=0, stay in DRIVE. a/b change on that edge.
  - At count==HOLD_CYCLES-1 with vec==3: go to DONE, busy=0, done=1.
  - a/b hold vec=3 in DONE; they return to 0 only on reset or the next start.
- State DONE:
  - Outputs stable.
  - start=1 restarts exactly as from IDLE: done drops and busy rises on the same edge.
- start while busy is ignored; no restart and no effect on func_q.
- Latency:
  - A full sweep is 4*HOLD_CYCLES cycles from the accepting edge to the edge asserting done (40 cycles at default).
  - a/b are registered, so each vector appears on the cycle after the counter condition.
- Expected value per func: AND a&b, OR a|b, XOR a^b, NAND ~(a&b).
- The y sample is a plain register compare with no synchronizer; the gate under test is combinational on the same clock domain.
- If y is X/Z at the sample point, it counts as a mismatch (use case-equality semantics in simulation).

Optional Feature:
- Macro: GATE_SWEEP_LOG_EN.
- Defined: adds output y_log [3:0], where bit n holds the y sampled for vec n.
  - Cleared to 0 on rst and on an accepted start.
  - Each bit is written at its vector's sample point.
  - Valid when done=1.
- Undefined: no y_log port and no log register; all other behaviour is identical.

Decomposition:
- Shared package gate_pkg holds:
  - func encodings FUNC_AND=2'd0, FUNC_OR=2'd1, FUNC_XOR=2'd2, FUNC_NAND=2'd3.
  - FSM state encoding ST_IDLE, ST_DRIVE, ST_DONE.
  - Function gate_expect(func, a, b), reused by future gate benches.
- One natural sub-module: sweep_hold_counter, a parameterized up-counter with clear and a terminal-count flag.
- The FSM and comparator stay in the top.

Test Plan:
- Reset then start with func=1 (OR) and an or_gate on y: a/b step 00, 01, 10, 11 every 10 cycles; done=1 at cycle 40; pass=1; err_count=0.
- func=1 with y tied to 0: mismatches on vectors 01, 10, 11; done=1; err_count=3; pass=0.
- func=0 (AND) with y driven by an OR gate: mismatches on 01 and 10; err_count=2. With GATE_SWEEP_LOG_EN, y_log=4'b1110.
- Pulse start again at cycle 15 of a sweep: ignored; done still at cycle 40 from the original start; err_count unchanged.
- Assert rst at cycle 25 mid-sweep: next cycle a=0, b=0, busy=0, done=0, err_count=0. A following start runs a clean full sweep.
- In DONE, start with func=2 (XOR) and an XOR gate on y: done drops on the accept edge and the new sweep passes. Repeat with HOLD_CYCLES=2, SAMPLE_AT=1: done 8 cycles after accept.
